pwm_medidor10: RTL and testbench

PWM_MEDIDOR10 -- requirements
Module: pwm_medidor10

---
 rtl/pwm_medidor10.sv | 84 ++++++++
 tb/tb_pwm_medidor10.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pwm_medidor10.sv
// pwm_medidor10: measures high time and period of an asynchronous PWM input in clk cycles.
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   pwm_in    in   asynchronous PWM waveform
//   duty      out  [9:0] high time of last complete period (1023/0 when input is constant)
//   periodo   out  [9:0] length of last complete period (0 when input is constant)
//   valid     out  one-cycle pulse when duty/periodo update
//   ovf       out  sticky: a measured period exceeded 1023 cycles
//   constante out  high while no rising edge has been seen for 1023 cycles
module pwm_medidor10 (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    output logic [9:0] duty,
    output logic [9:0] periodo,
    output logic       valid,
    output logic       ovf,
    output logic       constante
);
    typedef enum logic [1:0] {ARRANQUE, MIDE, FIJO} state_t;
    state_t     r_state, w_state_nxt;
    logic       r_sync1, r_s, r_prev;
    logic [9:0] r_per, r_alto;
    logic       w_rise, w_fall, w_sat, w_cap, w_fix, w_lvl;
    always_comb begin
        w_rise      = r_s & ~r_prev;
        w_fall      = ~r_s & r_prev;
        w_sat       = (r_per == 10'd1023);
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        w_fix       = 1'b0;
        w_lvl       = 1'b0;
        case (r_state)
            // first edge only arms the measurement; its partial period is thrown away
            ARRANQUE: if (w_rise) w_state_nxt = MIDE;
                      else if (w_sat) begin w_state_nxt = FIJO; w_fix = 1'b1; end
            MIDE:     if (w_rise) w_cap = 1'b1;
                      else if (w_sat) begin w_state_nxt = FIJO; w_fix = 1'b1; end
            // in FIJO a rising edge restarts measuring; only a falling level is reported
            FIJO:     if (w_rise) w_state_nxt = MIDE;
                      else if (w_fall) w_lvl = 1'b1;
            default:  w_state_nxt = ARRANQUE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ARRANQUE;
        else     r_state <= w_state_nxt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_s       <= 1'b0;
            r_prev    <= 1'b0;
            r_per     <= 10'd0;
            r_alto    <= 10'd0;
            duty      <= 10'd0;
            periodo   <= 10'd0;
            valid     <= 1'b0;
            ovf       <= 1'b0;
            constante <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_s     <= r_sync1;
            r_prev  <= r_s;
            // counters restart at 1 so the edge cycle itself belongs to the new period
            r_per   <= w_rise ? 10'd1 : w_sat ? r_per : r_per + 10'd1;
            r_alto  <= w_rise ? 10'd1 : (r_s && r_alto != 10'd1023) ? r_alto + 10'd1 : r_alto;
            valid   <= w_cap | w_fix | w_lvl;
            if (w_cap) begin
                duty    <= r_alto;
                periodo <= r_per;
            end
            if (w_fix) begin
                duty      <= r_s ? 10'd1023 : 10'd0;
                periodo   <= 10'd0;
                constante <= 1'b1;
            end
            if (w_lvl) duty <= 10'd0;
            // timing out before any edge was seen is not an overflow
            if (w_fix && r_state == MIDE) ovf <= 1'b1;
            if (w_rise && r_state == FIJO) constante <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pwm_medidor10.sv
// tb_pwm_medidor10: scoreboard bench for pwm_medidor10.
module tb_pwm_medidor10;
    logic       clk = 1'b0;
    logic       rst, pwm_in;
    logic [9:0] duty, periodo;
    logic       valid, ovf, constante;
    int n_tests = 0, n_fail = 0;
    typedef struct {int d; int p; int t;} exp_t;
    exp_t q[$];
    bit armed;
    int cur_h, cur_p, cur_t;

    pwm_medidor10 dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in), .duty(duty), .periodo(periodo),
        .valid(valid), .ovf(ovf), .constante(constante)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want, input int tol = 0);
        n_tests++;
        if (got > want + tol || got < want - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, want, tol);
        end
    endtask

    task automatic push(input int d, input int p, input int t);
        exp_t e;
        e.d = d;
        e.p = p;
        e.t = t;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic period(input int h, input int l);
        if (armed) push(cur_h, cur_p, cur_t);
        pwm_in = 1'b1;
        wait_cyc(h);
        pwm_in = 1'b0;
        wait_cyc(l);
        armed = 1'b1;
        cur_h = h;
        cur_p = h + l;
        cur_t = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_duty"}, duty, 0);
        check({tag, "_periodo"}, periodo, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_constante"}, constante, 0);
    endtask

    always @(negedge clk) begin
        if (valid) begin
            exp_t e;
            if (q.size() == 0) check("spurious_valid", 1, 0);
            else begin
                e = q.pop_front();
                check("duty", duty, e.d, e.t);
                check("periodo", periodo, e.p, e.t);
            end
        end
    end

    initial begin
        int ph, j;
        rst = 1'b1;
        pwm_in = 1'b0;
        armed = 1'b0;
        wait_cyc(3);
        check_zero("reset");
        rst = 1'b0;
        wait_cyc(2);
        repeat (5) period(25, 75);
        repeat (4) period(1, 9);
        repeat (4) period(9, 1);
        repeat (2) period(500, 523);
        check("ovf_1023", ovf, 0);
        push(cur_h, cur_p, 0);
        push(1023, 0, 0);
        armed = 1'b0;
        pwm_in = 1'b1;
        wait_cyc(2000);
        check("hold_ovf", ovf, 1);
        check("hold_constante", constante, 1);
        check("hold_duty", duty, 1023);
        check("hold_periodo", periodo, 0);
        push(0, 0, 0);
        pwm_in = 1'b0;
        wait_cyc(50);
        check("low_duty", duty, 0);
        check("low_ovf", ovf, 1);
        check("low_constante", constante, 1);
        pwm_in = 1'b1;
        wait_cyc(6);
        check("restart_constante", constante, 0);
        wait_cyc(34);
        pwm_in = 1'b0;
        wait_cyc(60);
        armed = 1'b1;
        cur_h = 40;
        cur_p = 100;
        cur_t = 0;
        repeat (2) period(40, 60);
        push(cur_h, cur_p, 0);
        pwm_in = 1'b1;
        wait_cyc(30);
        pwm_in = 1'b0;
        wait_cyc(20);
        rst = 1'b1;
        #1;
        check_zero("midrst");
        wait_cyc(3);
        rst = 1'b0;
        armed = 1'b0;
        wait_cyc(47);
        repeat (3) period(25, 75);
        ph = $urandom_range(1, 5);
        #(ph);
        repeat (3) begin
            if (armed) push(cur_h, cur_p, cur_t);
            pwm_in = 1'b1;
            j = $urandom_range(0, 4);
            #(3000 + j - 2);
            pwm_in = 1'b0;
            #(7000 - j + 2);
            armed = 1'b1;
            cur_h = 300;
            cur_p = 1000;
            cur_t = 1;
        end
        push(cur_h, cur_p, cur_t);
        pwm_in = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #2;
        check("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
